// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for pipe_stage_skid: upstream push side and downstream pop side.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 160
);
  logic              up_valid_i;
  logic              up_ready_o;
  logic [DATA_W-1:0] up_data_i;
  logic              dn_valid_o;
  logic              dn_ready_i;
  logic [DATA_W-1:0] dn_data_o;

  // The stage itself: consumes upstream, produces downstream.
  modport slave (
    input  up_valid_i, up_data_i, dn_ready_i,
    output up_ready_o, dn_valid_o, dn_data_o
  );

  // Surrounding logic: produces upstream, consumes downstream.
  modport master (
    output up_valid_i, up_data_i, dn_ready_i,
    input  up_ready_o, dn_valid_o, dn_data_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage: DEPTH-entry circular buffer with registered
// upstream ready, synchronous flush and synchronous active-low reset.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              rdy_q;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    push     = bus.up_valid_i & rdy_q;
    pop      = (cnt != '0) & bus.dn_ready_i;
    cnt_next = cnt + CNT_W'(push) - CNT_W'(pop);
  end

  // Ready is computed from the post-update occupancy, so a full buffer popped this
  // cycle only reopens on the following cycle; dn_ready_i never reaches up_ready_o.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      rdy_q <= 1'b0;
    end else if (flush_i) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      rdy_q <= 1'b1;
    end else begin
      if (push) wp <= ptr_inc(wp);
      if (pop)  rp <= ptr_inc(rp);
      cnt   <= cnt_next;
      rdy_q <= (cnt_next < CNT_W'(DEPTH));
    end
  end

  // Storage has no reset; entries are only meaningful while counted in cnt.
  always_ff @(posedge clk_i) begin
    if (rst_i && !flush_i && push) mem[wp] <= bus.up_data_i;
  end

  always_comb begin
    bus.up_ready_o = rdy_q;
    bus.dn_valid_o = (cnt != '0);
    bus.dn_data_o  = (cnt != '0) ? mem[rp] : '0;
    count_o        = cnt;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: three instances (DEPTH 2, 3, 1) checked every
// cycle against a queue-based reference model.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fl   [3];
  logic          vin  [3];
  logic          rin  [3];
  logic [DW-1:0] din  [3];

  logic          ov   [3];
  logic          ordy [3];
  logic [DW-1:0] od   [3];
  logic [DW-1:0] oc   [3];

  logic [1:0] c0;
  logic [1:0] c1;
  logic [0:0] c2;

  pipe_stage_skid_if #(.DATA_W(DW)) b0 ();
  pipe_stage_skid_if #(.DATA_W(DW)) b1 ();
  pipe_stage_skid_if #(.DATA_W(DW)) b2 ();

  pipe_stage_skid #(.DATA_W(DW), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fl[0]), .bus(b0.slave), .count_o(c0));
  pipe_stage_skid #(.DATA_W(DW), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fl[1]), .bus(b1.slave), .count_o(c1));
  pipe_stage_skid #(.DATA_W(DW), .DEPTH(1)) u_d1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(fl[2]), .bus(b2.slave), .count_o(c2));

  assign b0.up_valid_i = vin[0]; assign b0.up_data_i = din[0]; assign b0.dn_ready_i = rin[0];
  assign b1.up_valid_i = vin[1]; assign b1.up_data_i = din[1]; assign b1.dn_ready_i = rin[1];
  assign b2.up_valid_i = vin[2]; assign b2.up_data_i = din[2]; assign b2.dn_ready_i = rin[2];

  assign ov[0] = b0.dn_valid_o; assign ordy[0] = b0.up_ready_o; assign od[0] = b0.dn_data_o;
  assign ov[1] = b1.dn_valid_o; assign ordy[1] = b1.up_ready_o; assign od[1] = b1.dn_data_o;
  assign ov[2] = b2.dn_valid_o; assign ordy[2] = b2.up_ready_o; assign od[2] = b2.dn_data_o;
  assign oc[0] = DW'(c0);
  assign oc[1] = DW'(c1);
  assign oc[2] = DW'(c2);

  // Reference model: contents as a FIFO queue, plus the expected ready flag.
  logic [DW-1:0] mq [3][$];
  logic          mr [3];
  int            pops [3];
  int            checks = 0;
  int            errors = 0;

  function automatic int depth_of(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate handshakes from the model's view, advance, then compare all outputs.
  task automatic step();
    bit push [3];
    bit pop  [3];
    for (int i = 0; i < 3; i++) begin
      push[i] = vin[i] && mr[i];
      pop[i]  = (mq[i].size() != 0) && rin[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        mr[i] = 1'b0;
      end else if (fl[i]) begin
        mq[i].delete();
        mr[i] = 1'b1;
      end else begin
        if (pop[i]) begin
          void'(mq[i].pop_front());
          pops[i]++;
        end
        if (push[i]) mq[i].push_back(din[i]);
        mr[i] = (mq[i].size() < depth_of(i));
      end
      chk($sformatf("d%0d_valid", depth_of(i)), DW'(ov[i]), DW'(mq[i].size() != 0));
      chk($sformatf("d%0d_data", depth_of(i)), od[i], (mq[i].size() != 0) ? mq[i][0] : '0);
      chk($sformatf("d%0d_count", depth_of(i)), oc[i], DW'(mq[i].size()));
      chk($sformatf("d%0d_ready", depth_of(i)), DW'(ordy[i]), DW'(mr[i]));
    end
  endtask

  initial begin
    bit acc;
    int sent;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fl[i] = 1'b0; vin[i] = 1'b1; rin[i] = 1'b0; din[i] = 32'hDEAD_0000 + DW'(i);
      mr[i] = 1'b0; pops[i] = 0;
    end

    // Reset held 3 cycles with upstream valid asserted.
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rel_ready", DW'(ordy[0]), 1);
    chk("rel_count", oc[0], 0);
    for (int i = 0; i < 3; i++) vin[i] = 1'b0;
    step();

    // Streaming on DEPTH=2, consumer always ready.
    rin[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      vin[0] = 1'b1; din[0] = DW'(k);
      step();
      chk("stream_cnt_le1", DW'(oc[0] <= 1), 1);
      chk("stream_head", od[0], DW'(k));
    end
    vin[0] = 1'b0;
    repeat (2) step();

    // Backpressure until full, then drain with 0xC pending.
    rin[0] = 1'b0;
    vin[0] = 1'b1; din[0] = 32'hA; step();
    din[0] = 32'hB; step();
    chk("bp_full_cnt", oc[0], 2);
    chk("bp_full_rdy", DW'(ordy[0]), 0);
    din[0] = 32'hC; step();
    rin[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      acc = vin[0] && mr[0];
      step();
      if (acc) vin[0] = 1'b0;
    end
    chk("bp_drained", DW'(mq[0].size()), 0);

    // DEPTH=3 wraparound: 10 random payloads with random consumer stalls.
    sent = 0;
    for (int c = 0; c < 200 && (sent < 10 || mq[1].size() != 0); c++) begin
      if (!vin[1] && sent < 10) begin
        vin[1] = 1'($urandom_range(0, 1));
        din[1] = $urandom;
      end
      rin[1] = 1'($urandom_range(0, 1));
      acc = vin[1] && mr[1];
      step();
      if (acc) begin
        sent++;
        vin[1] = 1'b0;
      end
    end
    chk("d3_sent", DW'(sent), 10);
    chk("d3_empty", oc[1], 0);
    rin[1] = 1'b0;

    // Flush colliding with push and pop on DEPTH=2.
    rin[0] = 1'b0;
    vin[0] = 1'b1; din[0] = 32'h5; step();
    din[0] = 32'h6; step();
    fl[0] = 1'b1; din[0] = 32'h7; rin[0] = 1'b1;
    step();
    fl[0] = 1'b0; vin[0] = 1'b0;
    chk("fl_count", oc[0], 0);
    chk("fl_valid", DW'(ov[0]), 0);
    chk("fl_data", od[0], 0);
    chk("fl_ready", DW'(ordy[0]), 1);
    repeat (2) step();

    // DEPTH=1: one transfer every two cycles, ready alternating.
    rin[2] = 1'b1; vin[2] = 1'b1; din[2] = 32'h100;
    pops[2] = 0;
    for (int k = 0; k < 8; k++) begin
      acc = vin[2] && mr[2];
      step();
      chk("d1_toggle", DW'(ordy[2]), DW'(k % 2));
      if (acc) din[2] = din[2] + 1;
    end
    chk("d1_xfers", DW'(pops[2]), 4);
    vin[2] = 1'b0;
    step();

    // Mid-stream reset discards contents; first push afterwards has 1-cycle latency.
    rin[1] = 1'b0; vin[1] = 1'b1; din[1] = 32'h31; step();
    din[1] = 32'h32; step();
    rst_n = 1'b0; step();
    chk("mrst_count", oc[1], 0);
    rst_n = 1'b1; step();
    din[1] = 32'h33; step();
    vin[1] = 1'b0;
    chk("mrst_head", od[1], 32'h33);
    rin[1] = 1'b1; repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised valid/ready pipeline stage. Successor to the fixed EXU->LSU stage register.
- Carries one opaque payload bundle (sys info, wen/ren flags, rd, src1, imm, mask, npc, res, cnd, concatenated by the instantiator) through a DEPTH-entry circular buffer.
- up_ready_o is fully registered, so no combinational ready path crosses the stage.
- Synchronous flush supports branch and exception squash.
- Used between EXU and LSU, and reusable at any other stage boundary.

Parameters:
- DATA_W, 160, payload width in bits (>=1).
- DEPTH, 2, buffer entries (1..8, need not be a power of two). 1 gives half throughput; >=2 gives full throughput.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- flush_i  input  1  squash all buffered entries this cycle.
- up_valid_i  input  1  upstream payload valid.
- up_ready_o  output  1  stage can accept; registered.
- up_data_i  input  DATA_W  upstream payload.
- dn_valid_o  output  1  head entry valid.
- dn_ready_i  input  1  downstream accepts head.
- dn_data_o  output  DATA_W  head payload; all zeros when dn_valid_o=0.
- count_o  output  CNT_W  current occupancy.

Behaviour:
- State: storage array mem[DEPTH], write pointer wp, read pointer rp, counter cnt, registered ready rdy_q.
- Reset (rst_i=0 at a rising edge): wp=rp=0, cnt=0, rdy_q=0. Outputs: dn_valid_o=0, dn_data_o=0, count_o=0, up_ready_o=0. Storage contents are not cleared.
- rdy_q is 0 while rst_i=0. It rises on the first edge with rst_i=1 and means the stage is accepting.
- push = up_valid_i & up_ready_o; pop = dn_valid_o & dn_ready_i.
- Push writes mem[wp] <= up_data_i and advances wp. Pop advances rp.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. No power-of-two assumption.
- Counter: cnt_next = cnt + push - pop (saturation unreachable by construction).
- Ready: rdy_q <= (cnt_next < DEPTH). It does not depend combinationally on dn_ready_i. A full buffer is therefore not writable in the same cycle it is popped; ready reappears the next cycle.
- Output: dn_valid_o = (cnt != 0); dn_data_o = dn_valid_o ? mem[rp] : 0. No combinational path from up_* to dn_*.
- Latency: a payload pushed at edge N is visible on dn_data_o after edge N (1 cycle) when the buffer was empty.
- Order: strict FIFO.
- Throughput: DEPTH>=2 sustains 1 transfer/cycle with dn_ready_i held at 1. DEPTH=1 sustains 1 transfer per 2 cycles.
- Flush (flush_i=1, rst_i=1): wp=rp=0, cnt=0, rdy_q=1.
  - A push presented in the same cycle is dropped.
  - A pop in the same cycle completes from the downstream view (its data was valid), but has no effect on state.
- Reset priority: reset overrides flush. Reset mid-stream discards all entries; the first accepted payload after reset appears with 1-cycle latency as above.
- Payload stability: dn_data_o and dn_valid_o hold while dn_valid_o=1 & dn_ready_i=0 (AXI-style stability). Upstream must hold up_data_i while up_valid_i=1 & up_ready_o=0. The stage does not check this.
- count_o = cnt.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with up_valid_i=1, then release. Expect up_ready_o=0, dn_valid_o=0, dn_data_o=0 during reset; up_ready_o=1 exactly one cycle after release; no payload accepted before that.
- Streaming, DEPTH=2, dn_ready_i=1: push 0x1..0x8 on consecutive cycles. Expect dn_data_o 0x1..0x8 on consecutive cycles one cycle later, count_o <= 1, no bubbles.
- Backpressure/full, DEPTH=2: dn_ready_i=0, push 0xA, 0xB. Expect count_o=2, up_ready_o=0 the cycle after the second push, 0xC held off. Raise dn_ready_i: expect 0xA then 0xB then 0xC; up_ready_o returns to 1 one cycle after the first pop.
- DEPTH=3 wrap: push/pop 10 items with random dn_ready_i stalls. Expect in-order output and count_o always 0..3 matching a scoreboard.
- Flush collision: buffer holds 0x5, 0x6; assert flush_i with up_valid_i=1 (0x7) and dn_ready_i=1 in the same cycle. Next cycle expect count_o=0, dn_valid_o=0, dn_data_o=0, up_ready_o=1, and 0x7 never emitted.
- DEPTH=1: continuous up_valid_i and dn_ready_i=1. Expect exactly one transfer every 2 cycles, and up_ready_o toggling 1,0,1,0.
